aes_key_sched: RTL and testbench

AES_KEY_SCHED -- requirements
Module: aes_key_sched

---
 rtl/aes_pkg.sv | 29 ++
 rtl/aes_sbox_word.sv | 48 ++++
 rtl/aes_key_sched.sv | 227 ++++++++++++++++++++++
 tb/tb_aes_key_sched.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES definitions: mode encoding, key-size table and GF(2^8) xtime.
package aes_pkg;

  localparam int WORD = 32;

  localparam logic [1:0] MODE_128 = 2'd0;
  localparam logic [1:0] MODE_192 = 2'd1;
  localparam logic [1:0] MODE_256 = 2'd2;

  typedef struct packed {
    logic [3:0] nk;
    logic [3:0] nr;
  } key_cfg_t;

  function automatic key_cfg_t key_cfg(input logic [1:0] mode);
    key_cfg_t c;
    case (mode)
      MODE_192: begin c.nk = 4'd6; c.nr = 4'd12; end
      MODE_256: begin c.nk = 4'd8; c.nr = 4'd14; end
      default:  begin c.nk = 4'd4; c.nr = 4'd10; end
    endcase
    return c;
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

endpackage

// File: rtl/aes_sbox_word.sv
// Four parallel AES S-boxes on one word, computed as GF(2^8) inverse plus affine map.
module aes_sbox_word
  import aes_pkg::*;
(
  input  logic [WORD-1:0] word_in,
  output logic [WORD-1:0] word_out
);

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int k = 0; k < 8; k++) begin
      p  = p ^ (b[k] ? aa : 8'h00);
      aa = xtime(aa);
    end
    return p;
  endfunction

  // Inverse as x^254 = x^2 * x^4 * ... * x^128; zero maps to zero naturally.
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] r;
    logic [7:0] sq;
    r  = 8'h01;
    sq = x;
    for (int k = 1; k < 8; k++) begin
      sq = gf_mul(sq, sq);
      r  = gf_mul(r, sq);
    end
    return r;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [7:0] i;
    i = gf_inv(b);
    return i ^ {i[6:0], i[7]} ^ {i[5:0], i[7:6]} ^ {i[4:0], i[7:5]} ^ {i[3:0], i[7:4]} ^ 8'h63;
  endfunction

  // byte-wise substitution
  always_comb begin
    word_out = {WORD{1'b0}};
    for (int k = 0; k < WORD / 8; k++) begin
      word_out[8*k +: 8] = sbox(word_in[8*k +: 8]);
    end
  end

endmodule

// File: rtl/aes_key_sched.sv
// AES key expansion streaming one round key per 4 words with valid/ready output.
// AES_KEY_SCHED_AES256_EN enables AES-256 (8-word window); otherwise mode 2 runs as AES-128.
module aes_key_sched
  import aes_pkg::*;
#(
  parameter int WORD      = aes_pkg::WORD,
  parameter int MAX_KEY_L = 256
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [1:0]           mode,
  input  logic [MAX_KEY_L-1:0] key_in,
  output logic                 busy,
  output logic                 rk_valid,
  input  logic                 rk_ready,
  output logic [127:0]         rk_out,
  output logic [3:0]           rk_idx,
  output logic                 done
);

`ifdef AES_KEY_SCHED_AES256_EN
  localparam int NW = 8;
`else
  localparam int NW = 6;
`endif

  function automatic logic [1:0] norm_mode(input logic [1:0] m);
    case (m)
      MODE_192: return MODE_192;
`ifdef AES_KEY_SCHED_AES256_EN
      MODE_256: return MODE_256;
`endif
      default:  return MODE_128;
    endcase
  endfunction

  logic [1:0]        mode_q,     mode_d;
  logic [WORD-1:0]   win_q [NW];
  logic [WORD-1:0]   win_d [NW];
  logic [2:0]        kmod_q,     kmod_d;
  logic              first_q,    first_d;
  logic [1:0]        grp_q,      grp_d;
  logic [3:0]        rnd_q,      rnd_d;
  logic              gen_done_q, gen_done_d;
  logic [7:0]        rcon_q,     rcon_d;
  logic [3*WORD-1:0] buf_q,      buf_d;
  logic              busy_q,     busy_d;
  logic              rk_valid_q, rk_valid_d;
  logic [127:0]      rk_out_q,   rk_out_d;
  logic [3:0]        rk_idx_q,   rk_idx_d;
  logic              done_q,     done_d;

  key_cfg_t        cfg;
  key_cfg_t        ncfg;
  logic [WORD-1:0] kw [NW];
  logic [WORD-1:0] prev_w, old_w, sub_in, sub_out, new_w;
  logic            hs, stall, gen_en;

  assign cfg  = key_cfg(mode_q);
  assign ncfg = key_cfg(norm_mode(mode));

  generate
    if (MAX_KEY_L > NW * WORD) begin : g_key_tail
      logic key_unused;
      assign key_unused = ^key_in[MAX_KEY_L-NW*WORD-1:0];
    end
  endgenerate

  // split the left-aligned key into words, word 0 at the MSBs
  always_comb begin
    for (int j = 0; j < NW; j++) begin
      kw[j] = key_in[MAX_KEY_L-1-WORD*j -: WORD];
    end
  end

  // window taps: win_q[0] is w[i-1], win_q[Nk-1] is w[i-Nk]
  always_comb begin
    prev_w = win_q[0];
    old_w  = win_q[0];
    for (int k = 0; k < NW; k++) begin
      old_w = (k == int'(cfg.nk) - 1) ? win_q[k] : old_w;
    end
    sub_in = (kmod_q == 3'd0) ? {prev_w[WORD-9:0], prev_w[WORD-1:WORD-8]} : prev_w;
  end

  aes_sbox_word u_sbox (
    .word_in  (sub_in),
    .word_out (sub_out)
  );

  // next expanded word; during the first Nk words the window shifts the key out
  always_comb begin
    if (first_q) begin
      new_w = old_w;
    end else if (kmod_q == 3'd0) begin
      new_w = old_w ^ sub_out ^ {rcon_q, {(WORD-8){1'b0}}};
`ifdef AES_KEY_SCHED_AES256_EN
    end else if ((cfg.nk == 4'd8) && (kmod_q == 3'd4)) begin
      new_w = old_w ^ sub_out;
`endif
    end else begin
      new_w = old_w ^ prev_w;
    end
  end

  assign hs     = rk_valid_q & rk_ready;
  assign stall  = (grp_q == 2'd3) & rk_valid_q & ~rk_ready;
  assign gen_en = busy_q & ~gen_done_q & ~stall;

  // next-state: start capture, word generation, grouping and output handshake
  always_comb begin
    mode_d     = mode_q;
    win_d      = win_q;
    kmod_d     = kmod_q;
    first_d    = first_q;
    grp_d      = grp_q;
    rnd_d      = rnd_q;
    gen_done_d = gen_done_q;
    rcon_d     = rcon_q;
    buf_d      = buf_q;
    busy_d     = busy_q;
    rk_valid_d = rk_valid_q;
    rk_out_d   = rk_out_q;
    rk_idx_d   = rk_idx_q;
    done_d     = 1'b0;

    if (hs) begin
      rk_valid_d = 1'b0;
      if (rk_idx_q == cfg.nr) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end else begin
        busy_d = busy_q;
      end
    end else begin
      rk_valid_d = rk_valid_q;
    end

    if (start && !busy_q) begin
      mode_d     = norm_mode(mode);
      busy_d     = 1'b1;
      kmod_d     = 3'd0;
      first_d    = 1'b1;
      grp_d      = 2'd0;
      rnd_d      = 4'd0;
      gen_done_d = 1'b0;
      rcon_d     = 8'h01;
      // preload reversed so the oldest tap yields key word 0, 1, ... in turn
      for (int k = 0; k < NW; k++) begin
        win_d[k] = {WORD{1'b0}};
        for (int j = 0; j < NW; j++) begin
          win_d[k] = ((k < int'(ncfg.nk)) && (j == int'(ncfg.nk) - 1 - k)) ? kw[j] : win_d[k];
        end
      end
    end else if (gen_en) begin
      win_d[0] = new_w;
      for (int k = 1; k < NW; k++) begin
        win_d[k] = win_q[k-1];
      end
      if ({1'b0, kmod_q} == cfg.nk - 4'd1) begin
        kmod_d  = 3'd0;
        first_d = 1'b0;
      end else begin
        kmod_d  = kmod_q + 3'd1;
      end
      rcon_d = (!first_q && (kmod_q == 3'd0)) ? xtime(rcon_q) : rcon_q;
      if (grp_q == 2'd3) begin
        rk_out_d   = {buf_q, new_w};
        rk_idx_d   = rnd_q;
        rk_valid_d = 1'b1;
        rnd_d      = rnd_q + 4'd1;
        gen_done_d = (rnd_q == cfg.nr);
        grp_d      = 2'd0;
      end else begin
        buf_d = {buf_q[2*WORD-1:0], new_w};
        grp_d = grp_q + 2'd1;
      end
    end else begin
      win_d = win_q;
    end
  end

  // state registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mode_q     <= MODE_128;
      for (int k = 0; k < NW; k++) begin
        win_q[k] <= {WORD{1'b0}};
      end
      kmod_q     <= 3'd0;
      first_q    <= 1'b0;
      grp_q      <= 2'd0;
      rnd_q      <= 4'd0;
      gen_done_q <= 1'b0;
      rcon_q     <= 8'h00;
      buf_q      <= {(3*WORD){1'b0}};
      busy_q     <= 1'b0;
      rk_valid_q <= 1'b0;
      rk_out_q   <= 128'h0;
      rk_idx_q   <= 4'd0;
      done_q     <= 1'b0;
    end else begin
      mode_q     <= mode_d;
      win_q      <= win_d;
      kmod_q     <= kmod_d;
      first_q    <= first_d;
      grp_q      <= grp_d;
      rnd_q      <= rnd_d;
      gen_done_q <= gen_done_d;
      rcon_q     <= rcon_d;
      buf_q      <= buf_d;
      busy_q     <= busy_d;
      rk_valid_q <= rk_valid_d;
      rk_out_q   <= rk_out_d;
      rk_idx_q   <= rk_idx_d;
      done_q     <= done_d;
    end
  end

  assign busy     = busy_q;
  assign rk_valid = rk_valid_q;
  assign rk_out   = rk_out_q;
  assign rk_idx   = rk_idx_q;
  assign done     = done_q;

endmodule

// File: tb/tb_aes_key_sched.sv
// Directed bench for aes_key_sched: reference expansion feeds a scoreboard queue.
module tb_aes_key_sched;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [1:0]   mode;
  logic [255:0] key_in;
  logic         busy;
  logic         rk_valid;
  logic         rk_ready;
  logic [127:0] rk_out;
  logic [3:0]   rk_idx;
  logic         done;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [3:0]   idx;
    logic [127:0] rk;
  } exp_t;

  exp_t         sb_q[$];
  logic [7:0]   sbox_tb [256];
  logic [127:0] dut_rk  [16];

  localparam logic [255:0] KEY128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'hdeadbeef0123456789abcdeffedcba98};
  localparam logic [255:0] KEY192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
  localparam logic [255:0] KEY256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

  always #5 clk = ~clk;

  aes_key_sched dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .mode     (mode),
    .key_in   (key_in),
    .busy     (busy),
    .rk_valid (rk_valid),
    .rk_ready (rk_ready),
    .rk_out   (rk_out),
    .rk_idx   (rk_idx),
    .done     (done)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp_v);
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // S-box table by walking the multiplicative group with generator 3
  task automatic build_sbox();
    logic [7:0] p, q, x;
    p = 8'h01;
    q = 8'h01;
    do begin
      p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ {q[6:0], 1'b0};
      q = q ^ {q[5:0], 2'b00};
      q = q ^ {q[3:0], 4'b0000};
      if (q[7]) q = q ^ 8'h09;
      x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
      sbox_tb[p] = x ^ 8'h63;
    end while (p != 8'h01);
    sbox_tb[0] = 8'h63;
  endtask

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox_tb[w[31:24]], sbox_tb[w[23:16]], sbox_tb[w[15:8]], sbox_tb[w[7:0]]};
  endfunction

  function automatic logic [1:0] eff_mode(input logic [1:0] m);
    if (m == 2'd1) return 2'd1;
`ifdef AES_KEY_SCHED_AES256_EN
    if (m == 2'd2) return 2'd2;
`endif
    return 2'd0;
  endfunction

  task automatic push_expected(input logic [1:0] me, input logic [255:0] key);
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0]  rc;
    int nk, nr;
    exp_t e;
    nk = (me == 2'd1) ? 6 : (me == 2'd2) ? 8 : 4;
    nr = nk + 6;
    rc = 8'h01;
    for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
    for (int i = nk; i < 4 * (nr + 1); i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t  = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
      end else if (nk == 8 && i % nk == 4) begin
        t = sub_word(t);
      end
      w[i] = w[i-nk] ^ t;
    end
    for (int r = 0; r <= nr; r++) begin
      e.idx = 4'(r);
      e.rk  = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
      sb_q.push_back(e);
    end
  endtask

  task automatic run(input logic [1:0] m, input logic [255:0] key, input int pct,
                     input int exp_done_cyc, input int inject_cyc, input int abort_idx);
    int cyc, first_cyc;
    logic fin, stalled;
    logic [127:0] hold_out;
    logic [3:0]   hold_idx;
    exp_t e;
    for (int k = 0; k < 16; k++) dut_rk[k] = 128'h0;
    push_expected(eff_mode(m), key);
    @(negedge clk);
    start = 1'b1; mode = m; key_in = key;
    @(posedge clk); #1;
    start = 1'b0; mode = ~m; key_in = ~key;
    check("busy_after_start", busy, 1'b1);
    cyc = 0; first_cyc = -1; fin = 1'b0; stalled = 1'b0;
    hold_out = 128'h0; hold_idx = 4'd0;
    while (!fin && cyc < 4000) begin
      @(posedge clk); #1;
      cyc++;
      start = 1'b0;
      if (stalled) begin
        check("stall_valid", rk_valid, 1'b1);
        check("stall_rk_out", rk_out, hold_out);
        check("stall_rk_idx", rk_idx, hold_idx);
      end
      if (cyc == inject_cyc) begin
        start = 1'b1; mode = 2'd1; key_in = KEY192;
      end
      if (rk_valid && first_cyc < 0) first_cyc = cyc;
      if (abort_idx >= 0 && rk_valid && rk_idx == abort_idx[3:0]) begin
        reset = 1'b0; #1;
        check("rst_busy", busy, 1'b0);
        check("rst_rk_valid", rk_valid, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_rk_out", rk_out, 128'h0);
        check("rst_rk_idx", rk_idx, 4'd0);
        @(negedge clk); reset = 1'b1;
        repeat (6) begin
          @(posedge clk); #1;
          check("no_partial_rk", rk_valid, 1'b0);
          check("idle_after_reset", busy, 1'b0);
        end
        sb_q.delete();
        stalled = 1'b0;
        fin = 1'b1;
      end else begin
        if (done) begin
          check("scoreboard_empty_at_done", sb_q.size(), 0);
          check("busy_clear_at_done", busy, 1'b0);
          if (exp_done_cyc > 0) check("done_cycle", cyc, exp_done_cyc);
          fin = 1'b1;
        end
        rk_ready = (pct >= 100) ? 1'b1 : ($urandom_range(0, 99) < pct);
        if (rk_valid && rk_ready) begin
          check("scoreboard_nonempty", (sb_q.size() > 0), 1'b1);
          if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check("rk_idx", rk_idx, e.idx);
            check("rk_out", rk_out, e.rk);
          end
          dut_rk[rk_idx] = rk_out;
        end
        stalled  = rk_valid && !rk_ready;
        hold_out = rk_out;
        hold_idx = rk_idx;
      end
    end
    check("finished_in_budget", fin, 1'b1);
    if (abort_idx < 0) begin
      if (exp_done_cyc > 0) check("first_key_latency", first_cyc, 4);
      @(posedge clk); #1;
      check("done_single_cycle", done, 1'b0);
    end
    sb_q.delete();
    rk_ready = 1'b1;
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; mode = 2'd0; key_in = 256'h0; rk_ready = 1'b1;
    build_sbox();
    #1;
    check("reset_busy", busy, 1'b0);
    check("reset_rk_valid", rk_valid, 1'b0);
    check("reset_done", done, 1'b0);
    check("reset_rk_out", rk_out, 128'h0);
    check("reset_rk_idx", rk_idx, 4'd0);
    repeat (3) @(posedge clk);
    @(negedge clk); reset = 1'b1;
    repeat (2) @(posedge clk);

    // AES-128 with start retried mid-expansion using another key and mode
    run(2'd0, KEY128, 100, 45, 10, -1);
    check("aes128_rk1", dut_rk[1], 128'ha0fafe1788542cb123a339392a6c7605);
    check("aes128_rk10", dut_rk[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

    run(2'd1, KEY192, 100, 53, -1, -1);
    check("aes192_rk12", dut_rk[12], 128'he98ba06f448c773c8ecc720401002202);

`ifdef AES_KEY_SCHED_AES256_EN
    run(2'd2, KEY256, 100, 61, -1, -1);
    check("aes256_rk14", dut_rk[14], 128'hfe4890d1e6188d0b046df344706c631e);
`else
    run(2'd2, KEY256, 100, 45, -1, -1);
`endif

    // backpressure: ready asserted 30% of cycles
    run(2'd0, KEY128, 30, 0, -1, -1);
    check("bp_aes128_rk10", dut_rk[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

    run(2'd3, KEY128, 100, 45, -1, -1);

    // abort at round key 5, then a clean expansion
    run(2'd0, KEY128, 100, 0, -1, 5);
    run(2'd0, KEY128, 100, 45, -1, -1);
    check("after_reset_rk10", dut_rk[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
